// File: rtl/msrv32_ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_ahb_pkg
// Description : Shared AHB-Lite encodings and the data-memory responder state
//               type for the msrv32 data-memory slave.
// Contents    : HTRANS_* transfer-type codes, HRESP_* response codes,
//               dmem_state_e responder FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package msrv32_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    DMEM_IDLE = 3'd0,
    DMEM_WAIT = 3'd1,
    DMEM_DATA = 3'd2,
    DMEM_ERR1 = 3'd3,
    DMEM_ERR2 = 3'd4
  } dmem_state_e;

endpackage : msrv32_ahb_pkg
`default_nettype wire

// File: rtl/msrv32_byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_byte_merge
// Description : Combinational byte-lane merge. Each byte of the result comes
//               from new_word_i where the mask bit is set, else old_word_i.
// Ports       : old_word_i [31:0] - current word contents
//               new_word_i [31:0] - incoming write data
//               mask_i     [3:0]  - byte enables, bit n selects byte n
//               merged_o   [31:0] - merged word
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_byte_merge
  import msrv32_ahb_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_word_i,
  input  logic [3:0]  mask_i,
  output logic [31:0] merged_o
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign merged_o[8*b +: 8] = mask_i[b] ? new_word_i[8*b +: 8] : old_word_i[8*b +: 8];
  end

endmodule : msrv32_byte_merge
`default_nettype wire

// File: rtl/msrv32_ahb_dmem_slave.sv
`default_nettype none
// ============================================================================
// Module      : msrv32_ahb_dmem_slave
// Description : AHB-Lite data-memory responder. Byte-masked word writes and
//               word reads on an internal array, programmable wait states,
//               two-cycle ERROR response for out-of-range addresses, and
//               read-after-write forwarding for pipelined back-to-back access.
// Ports       : ms_riscv32_mp_clk_in - clock, rising edge
//               ms_riscv32_mp_rst_in - asynchronous active-high reset
//               hsel_in, haddr_in, htrans_in, hwrite_in, wr_mask_in
//                                    - address phase (mask sampled here)
//               hwdata_in            - write data, final data-phase cycle
//               hready_out, hresp_out, hrdata_out - data phase response
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_ahb_dmem_slave
  import msrv32_ahb_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        hsel_in,
  input  logic [31:0] haddr_in,
  input  logic [1:0]  htrans_in,
  input  logic        hwrite_in,
  input  logic [3:0]  wr_mask_in,
  input  logic [31:0] hwdata_in,
  output logic        hready_out,
  output logic        hresp_out,
  output logic [31:0] hrdata_out
);

  localparam int          IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] c_depth_w  = 32'(DEPTH);
  localparam logic [3:0]  c_ws_m1    = 4'(WAIT_STATES - 1);

  dmem_state_e    state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           write_q, write_d;
  logic [3:0]     mask_q, mask_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [31:0]    mem_q [DEPTH];

  logic [29:0]    w_word_off;
  logic           w_in_range;
  logic [IW-1:0]  w_new_idx;
  logic           w_accept;
  logic           w_commit;
  logic           w_load;
  logic [IW-1:0]  w_load_idx;
  logic [31:0]    w_merged;
  logic           w_unused_ok;

  // BASE_ADDR is word-aligned, so the word offset can be formed on bits [31:2].
  assign w_word_off = haddr_in[31:2] - BASE_ADDR[31:2];
  assign w_in_range = (haddr_in[31:2] >= BASE_ADDR[31:2]) && ({2'b00, w_word_off} < c_depth_w);
  assign w_new_idx  = w_word_off[IW-1:0];
  assign w_accept   = hsel_in & htrans_in[1] & hready_out;
  assign w_commit   = (state_q == DMEM_DATA) & write_q;
  assign w_unused_ok = &{1'b0, haddr_in[1:0], htrans_in[0]};

  // Shared by the array write port and the read-after-write forward path.
  msrv32_byte_merge u_merge (
    .old_word_i (mem_q[idx_q]),
    .new_word_i (hwdata_in),
    .mask_i     (mask_q),
    .merged_o   (w_merged)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    write_d    = write_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    w_load     = 1'b0;
    w_load_idx = idx_q;
    hready_out = 1'b1;
    hresp_out  = HRESP_OKAY;

    case (state_q)
      DMEM_WAIT: begin
        hready_out = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = DMEM_DATA;
          w_load  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DMEM_ERR1: begin
        hready_out = 1'b0;
        hresp_out  = HRESP_ERROR;
        state_d    = DMEM_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all drive hready_out high, so each is an
        // address-phase accept point.
        if (state_q == DMEM_ERR2) begin
          hresp_out = HRESP_ERROR;
        end
        state_d = DMEM_IDLE;
        if (w_accept) begin
          idx_d   = w_new_idx;
          write_d = hwrite_in;
          mask_d  = wr_mask_in;
          if (!w_in_range) begin
            state_d = DMEM_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = DMEM_WAIT;
            cnt_d   = c_ws_m1;
          end else begin
            state_d    = DMEM_DATA;
            w_load     = 1'b1;
            w_load_idx = w_new_idx;
          end
        end
      end
    endcase

    // A read entering DATA on the same edge a write to that word commits
    // must see the merged word, not the stale array contents.
    rdata_d = rdata_q;
    if (w_load) begin
      if (w_commit && (w_load_idx == idx_q)) begin
        rdata_d = w_merged;
      end else begin
        rdata_d = mem_q[w_load_idx];
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q <= DMEM_IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      mask_q  <= 4'h0;
      cnt_q   <= 4'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared; reset drops an in-flight write because the state
  // register leaves DATA asynchronously.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (w_commit) begin
      mem_q[idx_q] <= w_merged;
    end
  end

  assign hrdata_out = rdata_q;

endmodule : msrv32_ahb_dmem_slave
`default_nettype wire

// File: doc/msrv32_ahb_dmem_slave.md
Name: msrv32_ahb_dmem_slave

Overview:
AHB-Lite data-memory responder at the memory end of the msrv32 store/load path.
- Accepts the address phase driven by the core: word-aligned address, HTRANS, write request and byte write mask.
- Performs byte-masked word writes and word reads on an internal array.
- Inserts a programmable number of wait states.
- Returns the two-cycle AHB ERROR response for out-of-range addresses.

Parameters:
DEPTH, 1024, number of 32-bit words in the array.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word-aligned.
WAIT_STATES, 0, hready_out low cycles per transfer data phase (0..15).

Ports:
ms_riscv32_mp_clk_in  input  1  clock; all state updates on its rising edge
ms_riscv32_mp_rst_in  input  1  asynchronous, active-high reset
hsel_in  input  1  slave select
haddr_in  input  32  byte address; bits [1:0] ignored
htrans_in  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite_in  input  1  1 = write, 0 = read
wr_mask_in  input  4  byte enables for writes; sampled in address phase
hwdata_in  input  32  write data; sampled in the final data-phase cycle
hready_out  output  1  transfer complete / slave ready
hresp_out  output  1  0 OKAY, 1 ERROR
hrdata_out  output  32  read data; valid when hready_out=1 in a read data phase

Behaviour:
- Reset (async assert, sync release): state IDLE, hready_out=1, hresp_out=0, hrdata_out=0, wait counter=0. The array is not cleared. Any in-flight write is dropped.
- Transfer accept: hsel_in=1, htrans_in[1]=1, hready_out=1 at a clock edge. SEQ and NONSEQ are treated identically. Captured: word index (haddr_in-BASE_ADDR)>>2, hwrite_in, wr_mask_in.
- IDLE/BUSY, or hsel_in=0, at an accept point: no transfer; hready_out stays 1, hresp_out stays 0.
- Range check at accept: address < BASE_ADDR or index >= DEPTH -> ERR1 state.
  - ERR1: hready_out=0, hresp_out=1.
  - ERR2: hready_out=1, hresp_out=1.
  - No array access. The cycle after ERR2 returns to IDLE/accept.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on accept, go to WAIT if WAIT_STATES>0, else DATA.
  - WAIT: hready_out=0; counter loads WAIT_STATES-1 and decrements; on 0 go to DATA.
  - DATA: hready_out=1, hresp_out=0. On the closing edge, a write updates mem[idx] byte lanes where mask=1 from hwdata_in. A new transfer may be accepted on the same edge (pipelined back-to-back), otherwise go to IDLE.
- Read data: hrdata_out is registered, loaded with mem[idx] on the edge that enters DATA, held at all other times. Latency from address phase = WAIT_STATES+1 cycles.
- Read-after-write hazard: a read accepted in the DATA cycle of a write to the same index must return the merged data (old word with new masked bytes). Forward the merged word; do not read the stale array value.
- Write with wr_mask_in=4'b0000: completes OKAY, array unchanged.
- hsel_in or htrans_in changes during WAIT are ignored; the captured transfer completes.

Decomposition:
- Package msrv32_ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants.
  - HRESP_OKAY/ERROR constants.
  - dmem FSM state encoding.
- Sub-module msrv32_byte_merge: combinational; (old_word, new_word, mask) -> merged word. Used for the array write path and for read-after-write forwarding.

Test Plan:
- WAIT_STATES=0: write 32'hDEADBEEF mask 4'hF at 0x10, then read 0x10 -> one cycle each, hrdata_out=32'hDEADBEEF, hresp_out=0.
- Byte write 32'h0000AB00 mask 4'b0010 at 0x11 over word 32'h11223344 -> read returns 32'h1122AB44. Half write mask 4'b1100 data 32'hCAFE0000 -> 32'hCAFEAB44.
- WAIT_STATES=3: read -> hready_out low exactly 3 cycles, then data; a back-to-back second read is accepted in the completion cycle.
- Address BASE_ADDR+4*DEPTH -> hready_out=0/hresp_out=1, then hready_out=1/hresp_out=1; array unchanged; next valid transfer gives OKAY.
- Write 32'h55AA55AA to 0x20 immediately followed by read of 0x20 (pipelined) -> read returns 32'h55AA55AA.
- Reset asserted during WAIT of a write -> outputs return to reset values asynchronously; the word is unchanged afterwards.
